// File: rtl/approx_mul_ha_array_pipe.sv
// Pipelined unsigned approximate multiplier built from per-row-pair half-adder
// arrays whose column behaviour comes from a run-time programmable mode table.
module approx_mul_ha_array_pipe #(
  parameter  int WIDTH = 8,
  localparam int NARR  = WIDTH / 2,
  localparam int NCOL  = WIDTH - 1,
  localparam int AW    = $clog2(NARR * NCOL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [1:0]         cfg_mode,
  output logic               cfg_err,
  output logic               busy
);

  localparam int NENT = NARR * NCOL;
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {
    M_HA     = 2'b00,
    M_OR     = 2'b01,
    M_ACARRY = 2'b10,
    M_ELIM   = 2'b11
  } mode_t;

  mode_t             mode [NENT];
  logic              v1, v2, v3;
  logic [WIDTH-1:0]  x1, y1;
  logic [WIDTH:0]    t_c [NARR];
  logic [NCOL-1:0]   b_c [NARR];
  logic [WIDTH:0]    t2  [NARR];
  logic [NCOL-1:0]   b2  [NARR];
  logic [PW-1:0]     acc [NARR+1];
  logic              adv;
  logic              cfg_ok;

  assign adv      = !v3 || out_ready;
  assign in_ready = adv;
  assign busy     = v1 || v2 || v3;
  assign out_valid = v3;
  assign cfg_ok   = !busy && !in_valid && (int'(cfg_addr) < NENT);

  // Mode table writes and the write-rejection pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NENT; i++) mode[i] <= M_HA;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) mode[cfg_addr] <= mode_t'(cfg_mode);
    end
  end

  // HA arrays: array k pairs row 2k (weight c) with row 2k+1 (weight c+1).
  for (genvar k = 0; k < NARR; k++) begin : g_arr
    logic [NCOL:1] s_v, co_v;
    for (genvar j = 1; j <= NCOL; j++) begin : g_col
      logic a, b;
      assign a = x1[2*k] & y1[j];
      assign b = x1[2*k+1] & y1[j-1];
      // Column compressor selected by its mode entry.
      always_comb begin
        s_v[j]  = 1'b0;
        co_v[j] = 1'b0;
        case (mode[k*NCOL + j - 1])
          M_HA:     begin s_v[j] = a ^ b; co_v[j] = a & b; end
          M_OR:     begin s_v[j] = a | b; end
          M_ACARRY: begin co_v[j] = a;    end
          default:  ;
        endcase
      end
    end
    // Carries of columns 1..NCOL-1 land two bits above b's base; last carry tops t.
    assign t_c[k] = {co_v[NCOL], s_v, x1[2*k] & y1[0]};
    assign b_c[k] = {x1[2*k+1] & y1[WIDTH-1], co_v[NCOL-1:1]};
    assign acc[k+1] = acc[k]
                    + ((PW'(t2[k]) + (PW'(b2[k]) << 2)) << (2*k));
  end
  assign acc[0] = '0;

  // Three-stage pipeline sharing one advance enable; bubbles propagate as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      x1    <= '0;
      y1    <= '0;
      out_p <= '0;
      for (int unsigned k = 0; k < NARR; k++) begin
        t2[k] <= '0;
        b2[k] <= '0;
      end
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        x1 <= in_x;
        y1 <= in_y;
      end
      v2 <= v1;
      if (v1) begin
        for (int unsigned k = 0; k < NARR; k++) begin
          t2[k] <= t_c[k];
          b2[k] <= b_c[k];
        end
      end
      v3 <= v2;
      if (v2) out_p <= acc[NARR];
    end
  end

endmodule

// File: tb/tb_approx_mul_ha_array_pipe.sv
// Directed self-checking bench for approx_mul_ha_array_pipe (WIDTH = 8).
module tb_approx_mul_ha_array_pipe;

  localparam int WIDTH = 8;
  localparam int AW    = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_x, in_y;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [1:0]         cfg_mode;
  logic               cfg_err;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  approx_mul_ha_array_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One operation on an idle pipeline with out_ready=1; checks latency and product.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_y = y;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_p"}, out_p, exp);
  endtask

  task automatic cfg_write(input string tag, input logic [AW-1:0] addr,
                           input logic [1:0] m, input logic exp_err);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_mode = m;
    @(negedge clk);
    cfg_we = 1'b0;
    check({tag, "_err"}, cfg_err, exp_err);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0]  sx [4];
  logic [7:0]  sy [4];
  logic [15:0] exp_q [$];
  logic [15:0] held;
  logic [7:0]  rx, ry;
  int          idx, got, cyc, seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0;
    idle(3);
    // T1: reset state and exact products
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(1);
    check("idle_in_ready", in_ready, 1);
    run_op("t1_255x255", 8'd255, 8'd255, 16'd65025);
    run_op("t1_0x200", 8'd0, 8'd200, 16'd0);

    // T2: array0 column1 as OR, then back to exact
    cfg_write("t2_cfg_or", 5'd0, 2'b01, 1'b0);
    run_op("t2_or_3x3", 8'd3, 8'd3, 16'd7);
    cfg_write("t2_cfg_ha", 5'd0, 2'b00, 1'b0);
    run_op("t2_ha_3x3", 8'd3, 8'd3, 16'd9);

    // T3: eliminated columns
    cfg_write("t3_cfg_elim", 5'd0, 2'b11, 1'b0);
    run_op("t3_elim_3x3", 8'd3, 8'd3, 16'd5);
    for (int i = 1; i < 7; i++) cfg_write("t3_cfg_all", 5'(i), 2'b11, 1'b0);
    run_op("t3_all_1x255", 8'd1, 8'd255, 16'd1);
    for (int i = 0; i < 7; i++) cfg_write("t3_restore", 5'(i), 2'b00, 1'b0);
    run_op("t3_exact_3x3", 8'd3, 8'd3, 16'd9);

    // T4: back-to-back ops with the output stalled for a while
    sx = '{8'd12, 8'd200, 8'd7, 8'd255};
    sy = '{8'd10, 8'd3, 8'd9, 8'd2};
    idx = 0; got = 0; cyc = 0; held = '0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      out_ready = (cyc >= 8);
      #1;
      if (out_valid && !out_ready) begin
        check("t4_stall_in_ready", in_ready, 0);
        if (cyc > 4) check("t4_stall_p_stable", out_p, held);
        held = out_p;
      end
      if (out_valid && out_ready) begin
        check("t4_order_p", out_p, exp_q.pop_front());
        got++;
      end
      if (idx < 4) begin
        in_valid = 1'b1; in_x = sx[idx]; in_y = sy[idx];
        if (in_ready) begin
          exp_q.push_back(16'(sx[idx] * sy[idx]));
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("t4_count", got, 4);
    @(negedge clk);
    check("t4_no_dup", out_valid, 0);
    idle(3);

    // T5: rejected configuration writes leave the table alone
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_busy", busy, 1);
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_mode = 2'b11;
    @(negedge clk);
    cfg_we = 1'b0;
    check("t5_busy_err", cfg_err, 1);
    @(negedge clk);
    check("t5_err_pulse", cfg_err, 0);
    idle(4);
    cfg_write("t5_range", 5'd28, 2'b01, 1'b1);
    run_op("t5_old_table", 8'd3, 8'd3, 16'd9);

    // T6: reset with operations in flight
    cfg_write("t6_cfg_or", 5'd0, 2'b01, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd3;
    @(negedge clk);
    in_x = 8'd5; in_y = 8'd6;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    idle(2);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("t6_no_out_valid", seen, 0);
    run_op("t6_exact_after_rst", 8'd3, 8'd3, 16'd9);

    // Exact-mode random products
    for (int i = 0; i < 20; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      run_op("rand_exact", rx, ry, 16'(rx * ry));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
